// File: rtl/pe_pkg.sv
// Shared arithmetic for the PE output path: default widths, the
// requantisation limits, and the round / saturate helpers that the
// drain pipeline splits across its two stages.
package pe_pkg;

  localparam int PE_DATA_WIDTH  = 16;
  localparam int PE_OUT_WIDTH   = 8;
  localparam int PE_SHIFT_WIDTH = 4;
  localparam int PE_FIFO_DEPTH  = 4;

  typedef logic signed [PE_DATA_WIDTH-1:0] acc_t;
  // One guard bit so the rounding bias can never wrap the sum.
  typedef logic signed [PE_DATA_WIDTH:0]   rnd_t;
  typedef logic signed [PE_OUT_WIDTH-1:0]  out_t;
  typedef logic        [PE_SHIFT_WIDTH-1:0] shift_t;

  // Largest and smallest values representable at the output width.
  localparam rnd_t OUT_MAX = rnd_t'((1 <<< (PE_OUT_WIDTH - 1)) - 1);
  localparam rnd_t OUT_MIN = rnd_t'(-(1 <<< (PE_OUT_WIDTH - 1)));

  // Round-half-up arithmetic right shift: add half an output LSB, then shift.
  function automatic rnd_t round_shift(acc_t data, shift_t shift);
    rnd_t bias;
    rnd_t sum;
    bias = '0;
    if (shift != '0) bias = rnd_t'(1) <<< (shift - 1'b1);
    sum = rnd_t'(data) + bias;
    return sum >>> shift;
  endfunction

  // Clamp a rounded value into the signed output range.
  function automatic out_t saturate(rnd_t r);
    out_t res;
    if (r > OUT_MAX)      res = out_t'(OUT_MAX);
    else if (r < OUT_MIN) res = out_t'(OUT_MIN);
    else                  res = out_t'(r);
    return res;
  endfunction

  // Full requantisation in one call, for users that do not pipeline it.
  function automatic out_t sat_round(acc_t data, shift_t shift);
    return saturate(round_shift(data, shift));
  endfunction

endpackage

// File: rtl/acc_drain_if.sv
// Bundle between the accumulator, the drain stage and the writeback
// consumer: the finished-sum pulse going in and the valid/ready result
// stream coming out. The master side is the accumulator plus consumer.
interface acc_drain_if
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = PE_DATA_WIDTH,
  parameter int OUT_WIDTH   = PE_OUT_WIDTH,
  parameter int SHIFT_WIDTH = PE_SHIFT_WIDTH
);

  logic        [SHIFT_WIDTH-1:0] shift;
  logic signed [DATA_WIDTH-1:0]  acc_data;
  logic                          acc_valid;
  logic signed [OUT_WIDTH-1:0]   out_data;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output shift,
    output acc_data,
    output acc_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  shift,
    input  acc_data,
    input  acc_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered first-word-fall-through head.
// A push is refused only when full and not popping in the same cycle;
// a simultaneous push and pop on a full FIFO reuses the slot being freed.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_OUT_WIDTH,
  parameter int DEPTH = PE_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + 1'b1;
  assign dout    = head;
  assign count   = cnt;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Registered head: loads the next entry after a pop, or the incoming
  // entry when it becomes the only one; cleared when the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else if (do_pop) begin
      if (cnt == CW'(1)) head <= do_push ? din : '0;
      else               head <= mem[rd_nxt];
    end else if (do_push && empty) begin
      head <= din;
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Drain stage of the MAC PE. Each finished kernel sum is rounded and
// shifted on the first edge, saturated (and optionally rectified) on the
// second edge as it is written into the output FIFO, then handed to the
// writeback stage over valid/ready. Results arriving while the FIFO is
// full with no pop are dropped and flagged on the sticky overflow output.
// Optional build macro: ACC_DRAIN_RELU_EN forces negative results to zero.
module acc_drain
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = PE_DATA_WIDTH,
  parameter int OUT_WIDTH   = PE_OUT_WIDTH,
  parameter int SHIFT_WIDTH = PE_SHIFT_WIDTH,
  parameter int FIFO_DEPTH  = PE_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  acc_drain_if.slave                      bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow
);

  rnd_t                 r_p1;
  logic                 vld_p1;
  out_t                 sat_p2;
  logic [OUT_WIDTH-1:0] push_data_p2;
  logic [OUT_WIDTH-1:0] head_data;
  logic                 pop;
  logic                 full;
  logic                 empty;

  // ---- Stage 1: rounded arithmetic shift of the incoming sum ----
  // Valid pipeline; in-flight results are discarded by reset.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= bus.acc_valid;
  end

  // Rounded, shifted sum captured alongside its valid.
  always_ff @(posedge clk) begin
    r_p1 <= round_shift(bus.acc_data, bus.shift);
  end

  // ---- Stage 2: saturation, optional rectification, FIFO write ----
  assign sat_p2 = saturate(r_p1);

`ifdef ACC_DRAIN_RELU_EN
  assign push_data_p2 = sat_p2[OUT_WIDTH-1] ? '0 : sat_p2;
`else
  assign push_data_p2 = sat_p2;
`endif

  assign pop = ~empty & bus.out_ready;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .din   (push_data_p2),
    .pop   (pop),
    .dout  (head_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.out_data  = head_data;
  assign bus.out_valid = ~empty;

  // Sticky drop flag: a result arrived with the FIFO full and nothing leaving.
  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (vld_p1 && full && !pop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: directed scenarios followed by random traffic,
// each cycle compared against a transaction-level model (a queue of
// expected outputs plus the one result in flight).
module tb_acc_drain;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [2:0] count;
  logic       overflow;

  acc_drain_if #(.DATA_WIDTH(16), .OUT_WIDTH(8), .SHIFT_WIDTH(4)) bus ();

  acc_drain dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state.
  int q[$];
  bit s1_v;
  int s1_val;
  bit ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Requantise with plain integer arithmetic: round half up, shift, clamp.
  function automatic int ref_requant(input int d, input int sh);
    int v;
    v = d;
    if (sh > 0) v = v + (1 << (sh - 1));
    v = v >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`ifdef ACC_DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic cycle(input bit v, input int d, input int sh, input bit rdy, input bit r);
    logic signed [15:0] ds;
    int head;
    ds = d[15:0];
    rst           = r;
    bus.acc_valid = v;
    bus.acc_data  = ds;
    bus.shift     = sh[3:0];
    bus.out_ready = rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      s1_v = 1'b0;
      ovf  = 1'b0;
    end else begin
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (s1_v) begin
        if (q.size() < DEPTH) q.push_back(s1_val);
        else ovf = 1'b1;
      end
      s1_v = v;
      if (v) s1_val = ref_requant(int'(ds), sh);
    end
    #1;
    check("out_valid", {31'h0, bus.out_valid}, {31'h0, q.size() > 0});
    check("count", {29'h0, count}, 32'(q.size()));
    check("overflow", {31'h0, overflow}, {31'h0, ovf});
    if (q.size() > 0) begin
      head = q[0];
      check("out_data", {24'h0, bus.out_data}, {24'h0, head[7:0]});
    end
  endtask

  logic [7:0] exp_neg;

  initial begin
    rst = 1'b1;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    bus.shift     = '0;
    bus.out_ready = 1'b0;
    s1_v = 1'b0;
    s1_val = 0;
    ovf = 1'b0;

    // Reset state
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("rst_out_data", {24'h0, bus.out_data}, 32'h0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);

    // 1: 291 >> 4 rounded = 18, visible two edges after the pulse
    cycle(1, 16'h0123, 4, 1, 0);
    check("t1_lat1", {31'h0, bus.out_valid}, 32'h0);
    cycle(0, 0, 4, 0, 0);
    check("t1_valid", {31'h0, bus.out_valid}, 32'h1);
    check("t1_data", {24'h0, bus.out_data}, 32'h12);
    cycle(0, 0, 0, 1, 0);
    check("t1_drained", {31'h0, bus.out_valid}, 32'h0);

    // 2: saturation both ways
`ifdef ACC_DRAIN_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'h80;
`endif
    cycle(1, 16'h0200, 0, 0, 0);
    cycle(1, 16'hFE00, 0, 0, 0);
    check("t2_pos", {24'h0, bus.out_data}, 32'h7F);
    cycle(0, 0, 0, 1, 0);
    check("t2_neg", {24'h0, bus.out_data}, {24'h0, exp_neg});
    cycle(0, 0, 0, 1, 0);

    // 3: rounding of small values
    cycle(1, 16'hFFFA, 2, 0, 0);
    cycle(1, 16'h0006, 2, 0, 0);
`ifdef ACC_DRAIN_RELU_EN
    check("t3_neg1", {24'h0, bus.out_data}, 32'h00);
`else
    check("t3_neg1", {24'h0, bus.out_data}, 32'hFF);
`endif
    cycle(0, 0, 0, 1, 0);
    check("t3_half_up", {24'h0, bus.out_data}, 32'h02);
    cycle(0, 0, 0, 1, 0);

    // 4: overfill with consumer stalled, then release in order
    for (int i = 1; i <= 6; i++) cycle(1, i, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("t4_count", {29'h0, count}, 32'd4);
    check("t4_overflow", {31'h0, overflow}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check("t4_order", {24'h0, bus.out_data}, 32'(i));
      cycle(0, 0, 0, 1, 0);
    end
    check("t4_empty", {31'h0, bus.out_valid}, 32'h0);

    // 5: push and pop on a full FIFO loses nothing
    cycle(0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) cycle(1, 16 * i, 0, 0, 0);
    cycle(1, 99, 0, 0, 0);
    check("t5_full", {29'h0, count}, 32'd4);
    cycle(0, 0, 0, 1, 0);
    check("t5_count", {29'h0, count}, 32'd4);
    check("t5_no_ovf", {31'h0, overflow}, 32'h0);
    check("t5_head", {24'h0, bus.out_data}, 32'd32);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);

    // 6: reset with three queued and one in flight
    for (int i = 1; i <= 4; i++) cycle(1, 8 + i, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("t6_valid", {31'h0, bus.out_valid}, 32'h0);
    check("t6_count", {29'h0, count}, 32'd0);
    check("t6_ovf", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    check("t6_no_stale", {31'h0, bus.out_valid}, 32'h0);

    // Random traffic, with an occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 15)), bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
